fifo_mc_w1r1: RTL and testbench
===============================

FIFO_MC_W1R1 -- requirements
Module: fifo_mc_w1r1

Interface
REQ-001 Parameter WIDTH, default 8: data bits per entry, SHALL be >= 1.
REQ-002 Parameter NCHAN, default 4: independent channels, SHALL be >= 2; CHAN_W = $clog2(NCHAN).
REQ-003 Parameter CHDEPTH, default 8: entries per channel, SHALL be >= 2; PTR_W = $clog2(CHDEPTH), CNT_W = $clog2(CHDEPTH+1).
REQ-004 Parameter AFULL, default CHDEPTH-1: almost-full threshold, SHALL be in 1..CHDEPTH.
REQ-005 Parameter FLOPS_NOT_MEM, default 0: 0 selects RAM storage, 1 selects flop storage.
REQ-006 Port i_clk, input, 1: the only clock.
REQ-007 Port i_rst, input, 1: reset, asynchronous and active-high.
REQ-008 Port i_cg, input, 1: clock gate; when low, no state changes.
REQ-009 Port i_flush, input, NCHAN: per-channel synchronous flush.
REQ-010 Ports i_data (WIDTH), i_wchan (CHAN_W), i_valid (1), inputs: write data, channel, push request.
REQ-011 Port o_ready, output, NCHAN: per-channel not-full.
REQ-012 Ports o_data (WIDTH) output, i_rchan (CHAN_W) input, i_ready (1) input: read data for i_rchan, pop request.
REQ-013 Port o_valid, output, NCHAN: per-channel not-empty.
REQ-014 Ports o_pushed, o_popped, outputs, 1 each: push/pop accepted this cycle.
REQ-015 Port o_nEntries, output, NCHAN*CNT_W: packed per-channel occupancy, channel c at [c*CNT_W +: CNT_W].
REQ-016 Port o_almostFull, output, NCHAN: per-channel occupancy >= AFULL.

Function
REQ-017 Push SHALL occur when i_cg && i_valid && o_ready[i_wchan] && !i_flush[i_wchan]; data stored at channel i_wchan, its write pointer.
REQ-018 Pop SHALL occur when i_cg && i_ready && o_valid[i_rchan] && !i_flush[i_rchan]; read pointer of i_rchan advances.
REQ-019 o_pushed/o_popped SHALL equal the REQ-017/REQ-018 conditions, combinationally.
REQ-020 o_data SHALL combinationally show the head entry of channel i_rchan; value undefined when o_valid[i_rchan] is low.
REQ-021 Per-channel pointers SHALL be PTR_W+1 bits with a wrap bit; non-pow2 CHDEPTH wraps CHDEPTH-1 -> 0 and toggles the wrap bit.
REQ-022 o_valid[c] SHALL be low iff pointers equal incl. wrap bit; o_ready[c] low iff lower bits equal and wrap bits differ.
REQ-023 nEntries[c] SHALL +1 on push-only, -1 on pop-only, hold on both/neither, for that channel.
REQ-024 Push and pop to the same channel in one cycle SHALL both succeed when 0 < nEntries < CHDEPTH; when full only pop, when empty only push (no bypass; data visible next cycle).
REQ-025 Push and pop to different channels in one cycle SHALL be independent.
REQ-026 i_flush[c] with i_cg SHALL zero channel c pointers and count next cycle; it overrides push/pop to c; other channels unaffected.
REQ-027 Storage SHALL be one array of NCHAN*CHDEPTH entries addressed {chan, ptr}; flush/reset SHALL NOT clear data.
REQ-028 o_almostFull[c] SHALL be registered-count-derived (nEntries[c] >= AFULL), no combinational path from inputs.

Reset
REQ-029 While i_rst is high, all pointers and counts SHALL be 0 asynchronously: o_valid=0, o_ready=all ones, o_nEntries=0, o_almostFull=0.
REQ-030 Reset mid-operation SHALL discard all channels' contents; storage contents are unreset.

Structure
REQ-031 Package fifo_pkg SHALL hold width helper functions (ptr/count widths) and the per-channel status struct (valid, ready, nEntries, almostFull).
REQ-032 Sub-module fifo_chan_ctrl SHALL implement one channel's pointers, count, flags and flush; instantiated NCHAN times via generate.

Verification
REQ-033 Reset, then push 8 words 0x10..0x17 to chan 2 (CHDEPTH=8) -> o_ready[2]=0, o_nEntries[2]=8, o_almostFull[2]=1 after 7th push, other channels o_valid=0.
REQ-034 Interleave pushes A0,B0,A1 to chans 0,1,0, pop with i_rchan=0 twice then 1 -> o_data A0,A1,B0 in order.
REQ-035 Chan 1 full, same cycle push and pop chan 1 -> only pop occurs, o_pushed=0, count 7; repeat at count 4 -> both occur, count stays 4.
REQ-036 CHDEPTH=6, 20 push/pop pairs on chan 3 -> data order preserved across wrap, count never exceeds 6.
REQ-037 i_flush[0] with simultaneous push to chan 0 and pop from chan 1 -> chan 0 empty next cycle, o_pushed=0, chan 1 pop succeeds.
REQ-038 Assert i_rst asynchronously mid-burst with i_cg=0 -> outputs reach reset values before next i_clk edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared width helpers and the per-channel status record for the multi-channel FIFO.
package fifo_pkg;

  localparam int STAT_CNT_W = 16;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [STAT_CNT_W-1:0] n_entries;
    logic                  almost_full;
  } chan_status_t;

endpackage

// File: rtl/fifo_chan_ctrl.sv
// One channel's read/write pointers (with wrap bit), occupancy count, flags and flush.
module fifo_chan_ctrl
  import fifo_pkg::*;
#(
  parameter int CHDEPTH = 8,
  parameter int AFULL   = CHDEPTH - 1,
  localparam int PTR_W  = ptr_width(CHDEPTH),
  localparam int CNT_W  = cnt_width(CHDEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [PTR_W-1:0] o_wptr,
  output logic [PTR_W-1:0] o_rptr,
  output chan_status_t     o_status
);

  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_empty;
  logic             w_full;

  // The last slot wraps to zero and flips the wrap bit, so non-power-of-two depths work too.
  function automatic logic [PTR_W:0] ptr_inc(input logic [PTR_W:0] p);
    if (p[PTR_W-1:0] == PTR_W'(CHDEPTH - 1)) return {~p[PTR_W], {PTR_W{1'b0}}};
    return p + (PTR_W+1)'(1);
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_cg) begin
      if (i_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (i_push) r_wptr <= ptr_inc(r_wptr);
        if (i_pop)  r_rptr <= ptr_inc(r_rptr);
        if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
        else if (i_pop && !i_push) r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]) && (r_wptr[PTR_W] != r_rptr[PTR_W]);

  assign o_wptr               = r_wptr[PTR_W-1:0];
  assign o_rptr               = r_rptr[PTR_W-1:0];
  assign o_status.valid       = ~w_empty;
  assign o_status.ready       = ~w_full;
  assign o_status.n_entries   = STAT_CNT_W'(r_count);
  assign o_status.almost_full = (r_count >= CNT_W'(AFULL));

endmodule

// File: rtl/fifo_mc_w1r1.sv
// Multi-channel FIFO: one write port and one read port sharing a single storage array,
// each channel owning a CHDEPTH-entry region. Handshake: a push is taken when i_valid is
// high and the target channel is ready; a pop is taken when i_ready is high and the read
// channel is valid; both only while i_cg is high and the channel is not being flushed.
module fifo_mc_w1r1
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NCHAN         = 4,
  parameter int CHDEPTH       = 8,
  parameter int AFULL         = CHDEPTH - 1,
  parameter int FLOPS_NOT_MEM = 0,
  localparam int CHAN_W       = $clog2(NCHAN),
  localparam int CNT_W        = cnt_width(CHDEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cg,
  input  logic [NCHAN-1:0]       i_flush,
  input  logic [WIDTH-1:0]       i_data,
  input  logic [CHAN_W-1:0]      i_wchan,
  input  logic                   i_valid,
  output logic [NCHAN-1:0]       o_ready,
  output logic [WIDTH-1:0]       o_data,
  input  logic [CHAN_W-1:0]      i_rchan,
  input  logic                   i_ready,
  output logic [NCHAN-1:0]       o_valid,
  output logic                   o_pushed,
  output logic                   o_popped,
  output logic [NCHAN*CNT_W-1:0] o_nEntries,
  output logic [NCHAN-1:0]       o_almostFull
);

  localparam int PTR_W  = ptr_width(CHDEPTH);
  localparam int DEPTH  = NCHAN * CHDEPTH;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_wptr [NCHAN];
  logic [PTR_W-1:0]  w_rptr [NCHAN];
  chan_status_t      w_stat [NCHAN];
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;
  logic [WIDTH-1:0]  w_rdata;

  assign w_push   = i_cg && i_valid && o_ready[i_wchan] && !i_flush[i_wchan];
  assign w_pop    = i_cg && i_ready && o_valid[i_rchan] && !i_flush[i_rchan];
  assign o_pushed = w_push;
  assign o_popped = w_pop;

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    fifo_chan_ctrl #(
      .CHDEPTH (CHDEPTH),
      .AFULL   (AFULL)
    ) u_ctrl (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_cg     (i_cg),
      .i_flush  (i_flush[c]),
      .i_push   (w_push && (i_wchan == CHAN_W'(c))),
      .i_pop    (w_pop && (i_rchan == CHAN_W'(c))),
      .o_wptr   (w_wptr[c]),
      .o_rptr   (w_rptr[c]),
      .o_status (w_stat[c])
    );

    assign o_valid[c]      = w_stat[c].valid;
    assign o_ready[c]      = w_stat[c].ready;
    assign o_almostFull[c] = w_stat[c].almost_full;
    // The status record carries a wide count; narrow it to the port width, saturating.
    assign o_nEntries[c*CNT_W +: CNT_W] =
      (w_stat[c].n_entries > STAT_CNT_W'(CHDEPTH)) ? CNT_W'(CHDEPTH)
                                                   : w_stat[c].n_entries[CNT_W-1:0];
  end

  // Entry address is {chan, ptr} in the sense chan*CHDEPTH + ptr, dense for any depth.
  assign w_waddr = ADDR_W'(i_wchan) * ADDR_W'(CHDEPTH) + ADDR_W'(w_wptr[i_wchan]);
  assign w_raddr = ADDR_W'(i_rchan) * ADDR_W'(CHDEPTH) + ADDR_W'(w_rptr[i_rchan]);

  if (FLOPS_NOT_MEM == 0) begin : g_ram
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
      if (w_push) r_mem[w_waddr] <= i_data;
    end

    assign w_rdata = r_mem[w_raddr];
  end else begin : g_flops
    logic [DEPTH-1:0][WIDTH-1:0] r_flops;

    always_ff @(posedge i_clk) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_push && (w_waddr == ADDR_W'(e))) r_flops[e] <= i_data;
      end
    end

    assign w_rdata = r_flops[w_raddr];
  end

  assign o_data = w_rdata;

endmodule

// File: tb/tb_fifo_mc_w1r1.sv
// Bench for fifo_mc_w1r1: an 8-deep RAM instance and a 6-deep flop instance share stimulus
// and are both tracked by a per-channel queue model; directed tables and sequences on top.
module tb_fifo_mc_w1r1;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cg;
  logic [3:0]  i_flush;
  logic [7:0]  i_data;
  logic [1:0]  i_wchan;
  logic        i_valid;
  logic [1:0]  i_rchan;
  logic        i_ready;

  logic [3:0]  o_ready8, o_valid8, o_afull8;
  logic [7:0]  o_data8;
  logic        o_pushed8, o_popped8;
  logic [15:0] o_nent8;
  logic [3:0]  o_ready6, o_valid6, o_afull6;
  logic [7:0]  o_data6;
  logic        o_pushed6, o_popped6;
  logic [11:0] o_nent6;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mq [8][$];
  logic       mp_push [2];
  logic       mp_pop  [2];

  typedef struct {
    logic [3:0] flush;
    logic       valid;
    logic [1:0] wchan;
    logic [7:0] data;
    logic       ready;
    logic [1:0] rchan;
    logic       e_push;
    logic       e_pop;
    logic       e_dchk;
    logic [7:0] e_data;
  } vec_t;

  vec_t vt [$];

  always #5 i_clk = ~i_clk;

  fifo_mc_w1r1 #(.WIDTH(8), .NCHAN(4), .CHDEPTH(8)) dut8 (
    .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg), .i_flush(i_flush),
    .i_data(i_data), .i_wchan(i_wchan), .i_valid(i_valid), .o_ready(o_ready8),
    .o_data(o_data8), .i_rchan(i_rchan), .i_ready(i_ready), .o_valid(o_valid8),
    .o_pushed(o_pushed8), .o_popped(o_popped8), .o_nEntries(o_nent8),
    .o_almostFull(o_afull8)
  );

  fifo_mc_w1r1 #(.WIDTH(8), .NCHAN(4), .CHDEPTH(6), .FLOPS_NOT_MEM(1)) dut6 (
    .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg), .i_flush(i_flush),
    .i_data(i_data), .i_wchan(i_wchan), .i_valid(i_valid), .o_ready(o_ready6),
    .o_data(o_data6), .i_rchan(i_rchan), .i_ready(i_ready), .o_valid(o_valid6),
    .o_pushed(o_pushed6), .o_popped(o_popped6), .o_nEntries(o_nent6),
    .o_almostFull(o_afull6)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] fl, input logic v, input logic [1:0] wc,
                              input logic [7:0] d, input logic r, input logic [1:0] rc,
                              input logic ep, input logic eo, input logic ed,
                              input logic [7:0] edat);
    vec_t x;
    x.flush = fl; x.valid = v; x.wchan = wc; x.data = d; x.ready = r; x.rchan = rc;
    x.e_push = ep; x.e_pop = eo; x.e_dchk = ed; x.e_data = edat;
    return x;
  endfunction

  task automatic drv(input logic [3:0] fl, input logic v, input logic [1:0] wc,
                     input logic [7:0] d, input logic r, input logic [1:0] rc);
    i_flush = fl; i_valid = v; i_wchan = wc; i_data = d; i_ready = r; i_rchan = rc;
  endtask

  // Model: each channel is a queue bounded by its depth; flags follow from queue sizes.
  task automatic model_check();
    for (int m = 0; m < 2; m++) begin
      int          dep;
      string       p;
      logic [3:0]  ev, er, ea, av, ar, aa;
      logic [31:0] an;
      dep = (m == 0) ? 8 : 6;
      p   = (m == 0) ? "d8" : "d6";
      av  = (m == 0) ? o_valid8 : o_valid6;
      ar  = (m == 0) ? o_ready8 : o_ready6;
      aa  = (m == 0) ? o_afull8 : o_afull6;
      for (int c = 0; c < 4; c++) begin
        ev[c] = (mq[m*4+c].size() > 0);
        er[c] = (mq[m*4+c].size() < dep);
        ea[c] = (mq[m*4+c].size() >= dep - 1);
        an = (m == 0) ? 32'(o_nent8[c*4 +: 4]) : 32'(o_nent6[c*3 +: 3]);
        chk({p, " nentries"}, an, 32'(mq[m*4+c].size()));
      end
      chk({p, " valid"}, 32'(av), 32'(ev));
      chk({p, " ready"}, 32'(ar), 32'(er));
      chk({p, " almostfull"}, 32'(aa), 32'(ea));
      mp_push[m] = i_cg && i_valid && (mq[m*4+i_wchan].size() < dep) && !i_flush[i_wchan];
      mp_pop[m]  = i_cg && i_ready && (mq[m*4+i_rchan].size() > 0) && !i_flush[i_rchan];
      chk({p, " pushed"}, 32'((m == 0) ? o_pushed8 : o_pushed6), 32'(mp_push[m]));
      chk({p, " popped"}, 32'((m == 0) ? o_popped8 : o_popped6), 32'(mp_pop[m]));
      if (mq[m*4+i_rchan].size() > 0)
        chk({p, " data"}, 32'((m == 0) ? o_data8 : o_data6), 32'(mq[m*4+i_rchan][0]));
    end
  endtask

  task automatic model_update();
    if (!i_cg) return;
    for (int m = 0; m < 2; m++) begin
      if (mp_pop[m])  void'(mq[m*4+i_rchan].pop_front());
      if (mp_push[m]) mq[m*4+i_wchan].push_back(i_data);
      for (int c = 0; c < 4; c++) if (i_flush[c]) mq[m*4+c].delete();
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < 8; q++) mq[q].delete();
  endtask

  task automatic cycle();
    #1;
    model_check();
    @(posedge i_clk);
    model_update();
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " d8 valid"}, 32'(o_valid8), 32'h0);
    chk({nm, " d8 ready"}, 32'(o_ready8), 32'hF);
    chk({nm, " d8 nentries"}, 32'(o_nent8), 32'h0);
    chk({nm, " d8 almostfull"}, 32'(o_afull8), 32'h0);
    chk({nm, " d6 valid"}, 32'(o_valid6), 32'h0);
    chk({nm, " d6 ready"}, 32'(o_ready6), 32'hF);
    chk({nm, " d6 nentries"}, 32'(o_nent6), 32'h0);
    chk({nm, " d6 almostfull"}, 32'(o_afull6), 32'h0);
  endtask

  initial begin
    i_rst = 1'b1; i_cg = 1'b1;
    drv(4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    model_reset();
    #3;
    chk_reset_vals("reset");
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Fill channel 2 of the 8-deep instance; almost-full appears after the 7th push.
    for (int i = 0; i < 8; i++) begin
      drv(4'h0, 1'b1, 2'd2, 8'(8'h10 + i), 1'b0, 2'd0);
      cycle();
      if (i == 5) chk("afull before 7th push", 32'(o_afull8[2]), 32'h0);
      if (i == 6) chk("afull after 7th push", 32'(o_afull8[2]), 32'h1);
    end
    chk("chan2 full ready", 32'(o_ready8[2]), 32'h0);
    chk("chan2 full count", 32'(o_nent8[8 +: 4]), 32'h8);
    chk("other chans empty", 32'(o_valid8 & 4'b1011), 32'h0);

    vt.push_back(mk(4'h0, 1, 2'd2, 8'h18, 0, 2'd0, 0, 0, 0, 8'h00));
    vt.push_back(mk(4'h0, 0, 2'd0, 8'h00, 1, 2'd2, 0, 1, 1, 8'h10));
    vt.push_back(mk(4'h0, 1, 2'd2, 8'h19, 1, 2'd2, 1, 1, 1, 8'h11));
    vt.push_back(mk(4'h4, 1, 2'd2, 8'h1A, 1, 2'd2, 0, 0, 1, 8'h12));
    vt.push_back(mk(4'h0, 1, 2'd0, 8'hA0, 0, 2'd0, 1, 0, 0, 8'h00));
    vt.push_back(mk(4'h0, 1, 2'd1, 8'hB0, 0, 2'd0, 1, 0, 0, 8'h00));
    vt.push_back(mk(4'h0, 1, 2'd0, 8'hA1, 1, 2'd2, 1, 0, 0, 8'h00));
    vt.push_back(mk(4'h0, 0, 2'd0, 8'h00, 1, 2'd0, 0, 1, 1, 8'hA0));
    vt.push_back(mk(4'h0, 0, 2'd0, 8'h00, 1, 2'd0, 0, 1, 1, 8'hA1));
    vt.push_back(mk(4'h0, 0, 2'd0, 8'h00, 1, 2'd1, 0, 1, 1, 8'hB0));
    vt.push_back(mk(4'h0, 0, 2'd0, 8'h00, 1, 2'd1, 0, 0, 0, 8'h00));
    vt.push_back(mk(4'h0, 1, 2'd3, 8'h33, 1, 2'd3, 1, 0, 0, 8'h00));
    vt.push_back(mk(4'h0, 0, 2'd0, 8'h00, 1, 2'd3, 0, 1, 1, 8'h33));
    for (int i = 0; i < vt.size(); i++) begin
      drv(vt[i].flush, vt[i].valid, vt[i].wchan, vt[i].data, vt[i].ready, vt[i].rchan);
      #1;
      chk($sformatf("vec%0d pushed", i), 32'(o_pushed8), 32'(vt[i].e_push));
      chk($sformatf("vec%0d popped", i), 32'(o_popped8), 32'(vt[i].e_pop));
      if (vt[i].e_dchk) chk($sformatf("vec%0d data", i), 32'(o_data8), 32'(vt[i].e_data));
      cycle();
    end

    // Full channel: simultaneous push/pop only pops; mid-occupancy both succeed.
    for (int i = 0; i < 8; i++) begin
      drv(4'h0, 1'b1, 2'd1, 8'(8'h20 + i), 1'b0, 2'd0);
      cycle();
    end
    drv(4'h0, 1'b1, 2'd1, 8'h28, 1'b1, 2'd1);
    #1;
    chk("full pushpop pushed", 32'(o_pushed8), 32'h0);
    chk("full pushpop popped", 32'(o_popped8), 32'h1);
    chk("full pushpop data", 32'(o_data8), 32'h20);
    cycle();
    chk("full pushpop count", 32'(o_nent8[4 +: 4]), 32'h7);
    for (int i = 0; i < 3; i++) begin
      drv(4'h0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
      cycle();
    end
    drv(4'h0, 1'b1, 2'd1, 8'h29, 1'b1, 2'd1);
    #1;
    chk("mid pushpop pushed", 32'(o_pushed8), 32'h1);
    chk("mid pushpop popped", 32'(o_popped8), 32'h1);
    chk("mid pushpop data", 32'(o_data8), 32'h24);
    cycle();
    chk("mid pushpop count", 32'(o_nent8[4 +: 4]), 32'h4);
    drv(4'h2, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    cycle();

    // Flush of channel 0 beats a push to it while a pop on channel 1 proceeds.
    drv(4'h0, 1'b1, 2'd0, 8'h44, 1'b0, 2'd0); cycle();
    drv(4'h0, 1'b1, 2'd1, 8'h55, 1'b0, 2'd0); cycle();
    drv(4'h1, 1'b1, 2'd0, 8'h66, 1'b1, 2'd1);
    #1;
    chk("flush push blocked", 32'(o_pushed8), 32'h0);
    chk("flush other pop", 32'(o_popped8), 32'h1);
    chk("flush other data", 32'(o_data8), 32'h55);
    cycle();
    chk("flushed chan0 valid", 32'(o_valid8[0]), 32'h0);
    chk("flushed chan0 count", 32'(o_nent8[0 +: 4]), 32'h0);
    chk("popped chan1 count", 32'(o_nent8[4 +: 4]), 32'h0);

    // Six-deep channel 3: keep 5 entries while 20 push/pop pairs wrap the pointers.
    for (int k = 0; k < 5; k++) begin
      drv(4'h0, 1'b1, 2'd3, 8'(8'h80 + k), 1'b0, 2'd0);
      cycle();
    end
    for (int j = 0; j < 20; j++) begin
      drv(4'h0, 1'b1, 2'd3, 8'(8'h85 + j), 1'b1, 2'd3);
      #1;
      chk($sformatf("wrap pair%0d data", j), 32'(o_data6), 32'(8'h80 + j));
      chk($sformatf("wrap pair%0d both", j), 32'({o_pushed6, o_popped6}), 32'h3);
      cycle();
      chk($sformatf("wrap pair%0d count", j), 32'(o_nent6[9 +: 3]), 32'h5);
    end
    drv(4'h8, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    cycle();

    // Random traffic: fill-biased first half, drain-biased second half.
    for (int it = 0; it < 300; it++) begin
      logic [3:0] fl;
      for (int c = 0; c < 4; c++) fl[c] = ($urandom_range(0, 99) < 3);
      i_cg = ($urandom_range(0, 9) != 0);
      drv(fl, ($urandom_range(0, 99) < ((it < 150) ? 75 : 35)), 2'($urandom_range(0, 3)),
          8'($urandom_range(0, 255)), ($urandom_range(0, 99) < ((it < 150) ? 35 : 75)),
          2'($urandom_range(0, 3)));
      cycle();
    end
    i_cg = 1'b1;

    // Asynchronous reset mid-burst with the clock gate low.
    for (int i = 0; i < 3; i++) begin
      drv(4'h0, 1'b1, 2'(i), 8'(8'hC0 + i), 1'b0, 2'd0);
      cycle();
    end
    chk("pre-reset busy", 32'(o_valid8 != 4'h0), 32'h1);
    drv(4'h0, 1'b1, 2'd0, 8'hC7, 1'b0, 2'd0);
    #2;
    i_cg = 1'b0; i_rst = 1'b1;
    #1;
    chk_reset_vals("async reset");
    model_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_cg = 1'b1;
    drv(4'h0, 1'b1, 2'd1, 8'h77, 1'b0, 2'd0); cycle();
    drv(4'h0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1); cycle();
    drv(4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
